// File: rtl/piso_tx_arbiter_controller_if.sv
// Requester/PISO-side signal bundle for the PISO transmit arbiter controller.
interface piso_tx_arbiter_controller_if #(
    parameter int DATA_WIDTH = 8
);
    logic [1:0]            Req_In;
    logic [DATA_WIDTH-1:0] Data0_In;
    logic [DATA_WIDTH-1:0] Data1_In;
    logic [1:0]            Ack_Out;
    logic                  Load_Shiftb_Out;
    logic [DATA_WIDTH-1:0] Parallel_Data_Out;
    logic                  Serial_Valid_Out;
    logic                  Frame_Start_Out;
    logic                  Grant_Id_Out;
    logic                  Busy_Out;

    // requesters drive requests and data, observe handshake and PISO controls
    modport master (
        output Req_In, Data0_In, Data1_In,
        input  Ack_Out, Load_Shiftb_Out, Parallel_Data_Out,
        input  Serial_Valid_Out, Frame_Start_Out, Grant_Id_Out, Busy_Out
    );

    // controller side
    modport slave (
        input  Req_In, Data0_In, Data1_In,
        output Ack_Out, Load_Shiftb_Out, Parallel_Data_Out,
        output Serial_Valid_Out, Frame_Start_Out, Grant_Id_Out, Busy_Out
    );
endinterface

// File: rtl/piso_tx_arbiter_controller.sv
// Round-robin arbiter and load/shift sequencer for an external PISO.
// Frame: IDLE (arbitrate) -> LOAD (1) -> SHIFT (DATA_WIDTH) -> GAP (GAP_CYCLES) -> IDLE.
module piso_tx_arbiter_controller #(
    parameter int DATA_WIDTH = 8,
    parameter int GAP_CYCLES = 1
) (
    input  logic                          Clk_In,
    input  logic                          Reset_In,
    piso_tx_arbiter_controller_if.slave   bus
);
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_SHIFT = 2'd2;
    localparam logic [1:0] ST_GAP   = 2'd3;

    localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [CW-1:0] BIT_LAST = CW'(DATA_WIDTH - 1);
    // GAP_CYCLES=0 never enters GAP; clamp so the constant stays non-negative
    localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    logic [1:0]            state;
    logic [CW-1:0]         bit_cnt;
    logic [GW-1:0]         gap_cnt;
    logic                  rr_prio;   // requester holding priority on a tie
    logic                  grant_id;
    logic [DATA_WIDTH-1:0] pdata;
    logic                  win;

    // winner: a lone requester wins outright, a tie goes to the priority holder
    always_comb begin
        win = rr_prio;
        if (bus.Req_In == 2'b01)
            win = 1'b0;
        else if (bus.Req_In == 2'b10)
            win = 1'b1;
    end

    // frame sequencer, bit/gap counters and captured grant
    always_ff @(posedge Clk_In) begin
        if (Reset_In) begin
            state    <= ST_IDLE;
            bit_cnt  <= '0;
            gap_cnt  <= '0;
            rr_prio  <= 1'b0;
            grant_id <= 1'b0;
            pdata    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (|bus.Req_In) begin
                        grant_id <= win;
                        pdata    <= win ? bus.Data1_In : bus.Data0_In;
                        rr_prio  <= ~win;
                        state    <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    bit_cnt <= BIT_LAST;
                    state   <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    if (bit_cnt == '0) begin
                        if (GAP_CYCLES > 0) begin
                            gap_cnt <= GAP_LAST;
                            state   <= ST_GAP;
                        end else begin
                            state   <= ST_IDLE;
                        end
                    end else begin
                        bit_cnt <= bit_cnt - 1'b1;
                    end
                end
                ST_GAP: begin
                    if (gap_cnt == '0)
                        state <= ST_IDLE;
                    else
                        gap_cnt <= gap_cnt - 1'b1;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // outputs decode from registered state only; nothing combinational from Req_In
    assign bus.Ack_Out           = (state == ST_LOAD) ? (grant_id ? 2'b10 : 2'b01) : 2'b00;
    assign bus.Load_Shiftb_Out   = (state == ST_LOAD);
    assign bus.Serial_Valid_Out  = (state == ST_SHIFT);
    assign bus.Frame_Start_Out   = (state == ST_SHIFT) && (bit_cnt == BIT_LAST);
    assign bus.Busy_Out          = (state != ST_IDLE);
    assign bus.Grant_Id_Out      = grant_id;
    assign bus.Parallel_Data_Out = pdata;

endmodule
